gamma_ram_sequencer: RTL and testbench

- Controller for the 128 x 12-bit signed branch-metric (gamma) RAM in the MAP decoder.
- Loads one block of gamma metrics, then replays it to the recursion units: ascending order for forward (alpha) and descending order for backward (beta), both in the same cycles.
- Drives the RAM write strobe (active-low), read enable, write address and both 1-based read addresses.
- Tags returned RAM data with valid flags and the trellis step index.

---
 rtl/gamma_ram_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_gamma_ram_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gamma_ram_sequencer.sv
// Gamma RAM sequencer: loads one block of branch metrics, then replays it ascending (alpha) and
// descending (beta) in the same cycles. Define GAMMA_SEQ_HOLD_EN to add a read-stall input "hold".
module gamma_ram_sequencer #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned IDXW  = 13,
    parameter int unsigned DW    = 12,
    parameter int unsigned LENW  = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [LENW-1:0] blk_len,
    input  logic            in_valid,
    input  logic [DW-1:0]   in_data,
`ifdef GAMMA_SEQ_HOLD_EN
    input  logic            hold,
`endif
    output logic            in_ready,
    output logic            ram_rdwr1,
    output logic            ram_rdwr2,
    output logic [IDXW-1:0] ram_index,
    output logic [IDXW-1:0] ram_index2,
    output logic [IDXW-1:0] ram_index3,
    output logic [DW-1:0]   ram_wdata,
    output logic            fwd_valid,
    output logic            bwd_valid,
    output logic [LENW-1:0] step_idx,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [LENW-1:0] n_q, n_d;
    logic [LENW-1:0] wcnt_q, wcnt_d;
    logic [LENW-1:0] rcnt_q, rcnt_d;
    logic [LENW-1:0] rd_step_q, rd_step_d;
    logic            in_ready_q, in_ready_d;
    logic            ram_rdwr1_q, ram_rdwr1_d;
    logic            ram_rdwr2_q, ram_rdwr2_d;
    logic [IDXW-1:0] ram_index_q, ram_index_d;
    logic [IDXW-1:0] ram_index2_q, ram_index2_d;
    logic [IDXW-1:0] ram_index3_q, ram_index3_d;
    logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
    logic            fwd_valid_q, fwd_valid_d;
    logic            bwd_valid_q, bwd_valid_d;
    logic [LENW-1:0] step_idx_q, step_idx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            len_ok_c;
    logic            hold_c;

`ifdef GAMMA_SEQ_HOLD_EN
    assign hold_c = hold;
`else
    assign hold_c = 1'b0;
`endif

    assign len_ok_c = (blk_len != '0) && (blk_len <= LENW'(DEPTH));

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        rd_step_d    = rd_step_q;
        ram_rdwr1_d  = 1'b1;
        ram_rdwr2_d  = 1'b0;
        ram_index_d  = ram_index_q;
        ram_index2_d = ram_index2_q;
        ram_index3_d = ram_index3_q;
        ram_wdata_d  = ram_wdata_q;
        done_d       = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len_ok_c) begin
                        n_d     = blk_len;
                        wcnt_d  = '0;
                        rcnt_d  = '0;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    ram_rdwr1_d = 1'b0;
                    ram_index_d = IDXW'(wcnt_q);
                    ram_wdata_d = in_data;
                    if (wcnt_q == n_q - LENW'(1)) begin
                        state_d = S_READ;
                    end else begin
                        wcnt_d = wcnt_q + LENW'(1);
                    end
                end
            end
            S_READ: begin
                // A held slot issues nothing and leaves the read addresses untouched
                if (!hold_c) begin
                    ram_rdwr2_d  = 1'b1;
                    ram_index2_d = IDXW'(rcnt_q) + IDXW'(1);
                    ram_index3_d = IDXW'(n_q) - IDXW'(rcnt_q);
                    rd_step_d    = rcnt_q;
                    if (rcnt_q == n_q - LENW'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        rcnt_d = rcnt_q + LENW'(1);
                    end
                end
            end
            S_DRAIN: begin
                ram_index2_d = '0;
                ram_index3_d = '0;
                // Last read still in the RAM: its data and done appear together next cycle
                done_d = ram_rdwr2_q;
                if (!ram_rdwr2_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);
        fwd_valid_d = ram_rdwr2_q;
        bwd_valid_d = ram_rdwr2_q;
        step_idx_d  = ram_rdwr2_q ? rd_step_q : step_idx_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            rd_step_q    <= '0;
            in_ready_q   <= 1'b0;
            ram_rdwr1_q  <= 1'b1;
            ram_rdwr2_q  <= 1'b0;
            ram_index_q  <= '0;
            ram_index2_q <= '0;
            ram_index3_q <= '0;
            ram_wdata_q  <= '0;
            fwd_valid_q  <= 1'b0;
            bwd_valid_q  <= 1'b0;
            step_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            rd_step_q    <= rd_step_d;
            in_ready_q   <= in_ready_d;
            ram_rdwr1_q  <= ram_rdwr1_d;
            ram_rdwr2_q  <= ram_rdwr2_d;
            ram_index_q  <= ram_index_d;
            ram_index2_q <= ram_index2_d;
            ram_index3_q <= ram_index3_d;
            ram_wdata_q  <= ram_wdata_d;
            fwd_valid_q  <= fwd_valid_d;
            bwd_valid_q  <= bwd_valid_d;
            step_idx_q   <= step_idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign ram_rdwr1  = ram_rdwr1_q;
    assign ram_rdwr2  = ram_rdwr2_q;
    assign ram_index  = ram_index_q;
    assign ram_index2 = ram_index2_q;
    assign ram_index3 = ram_index3_q;
    assign ram_wdata  = ram_wdata_q;
    assign fwd_valid  = fwd_valid_q;
    assign bwd_valid  = bwd_valid_q;
    assign step_idx   = step_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_gamma_ram_sequencer.sv
// Testbench for gamma_ram_sequencer: behavioural gamma RAM, event monitor and per-block reference
// expectations. Exercises the hold input when GAMMA_SEQ_HOLD_EN is defined.
module tb_gamma_ram_sequencer;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned IDXW  = 13;
    localparam int unsigned DW    = 12;
    localparam int unsigned LENW  = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic [LENW-1:0] blk_len;
    logic            in_valid;
    logic [DW-1:0]   in_data;
`ifdef GAMMA_SEQ_HOLD_EN
    logic            hold;
`endif
    logic            in_ready, ram_rdwr1, ram_rdwr2;
    logic [IDXW-1:0] ram_index, ram_index2, ram_index3;
    logic [DW-1:0]   ram_wdata;
    logic            fwd_valid, bwd_valid, busy, done, err;
    logic [LENW-1:0] step_idx;

    always #5 clock = ~clock;

    gamma_ram_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .blk_len    (blk_len),
        .in_valid   (in_valid),
        .in_data    (in_data),
`ifdef GAMMA_SEQ_HOLD_EN
        .hold       (hold),
`endif
        .in_ready   (in_ready),
        .ram_rdwr1  (ram_rdwr1),
        .ram_rdwr2  (ram_rdwr2),
        .ram_index  (ram_index),
        .ram_index2 (ram_index2),
        .ram_index3 (ram_index3),
        .ram_wdata  (ram_wdata),
        .fwd_valid  (fwd_valid),
        .bwd_valid  (bwd_valid),
        .step_idx   (step_idx),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // Gamma RAM: write on low strobe, one-cycle registered read on 1-based addresses
    logic signed [DW-1:0] mem [0:DEPTH-1];
    logic signed [DW-1:0] fwd_rdata, bwd_rdata;
    always @(posedge clock) begin
        if (!ram_rdwr1) mem[7'(ram_index)] <= ram_wdata;
        if (ram_rdwr2) begin
            fwd_rdata <= mem[7'(ram_index2 - 13'd1)];
            bwd_rdata <= mem[7'(ram_index3 - 13'd1)];
        end
    end

    typedef struct { int addr; int data; int cyc; } wr_t;
    typedef struct { int i2; int i3; int cyc; } rd_t;
    typedef struct { int step; int f; int b; int cyc; } vl_t;

    wr_t wq[$];
    rd_t rq[$];
    vl_t vq[$];
    int  acc_q[$];
    int  cyc = 0;
    int  done_cnt = 0, done_cyc = 0, err_cnt = 0, bv_bad = 0;
    int  checks = 0, errors = 0;
    logic signed [DW-1:0] m [0:DEPTH-1];

    always @(posedge clock) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle
    always @(negedge clock) begin
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (!ram_rdwr1) wq.push_back(wr_t'{int'(ram_index), int'($signed(ram_wdata)), cyc});
        if (ram_rdwr2) rq.push_back(rd_t'{int'(ram_index2), int'(ram_index3), cyc});
        if (fwd_valid) vq.push_back(vl_t'{int'(step_idx), int'(fwd_rdata), int'(bwd_rdata), cyc});
        if (fwd_valid != bwd_valid) bv_bad = bv_bad + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (err) err_cnt = err_cnt + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdwr1"}, int'(ram_rdwr1), 1);
        chk({tag, "_rdwr2"}, int'(ram_rdwr2), 0);
        chk({tag, "_index"}, int'(ram_index), 0);
        chk({tag, "_index2"}, int'(ram_index2), 0);
        chk({tag, "_index3"}, int'(ram_index3), 0);
        chk({tag, "_wdata"}, int'(ram_wdata), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_fwd_valid"}, int'(fwd_valid), 0);
        chk({tag, "_bwd_valid"}, int'(bwd_valid), 0);
        chk({tag, "_step_idx"}, int'(step_idx), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    // Start a block and stream m[0..len-1]; returns during the first READ cycle.
    // start stays high (blk_len=0) while loading, which must be ignored.
    task automatic load_block(input int len, input int mode);
        int sent = 0;
        int tog = 0;
        int guard = 0;
        @(posedge clock); #1;
        start = 1'b1;
        blk_len = LENW'(len);
        @(posedge clock); #1;
        blk_len = '0;
        while (sent < len && guard < 4 * DEPTH + 20) begin
            guard++;
            if (in_ready) begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (tog == 0);
                    default: in_valid = ($urandom_range(0, 2) != 0);
                endcase
                tog = 1 - tog;
                in_data = m[sent];
                if (in_valid) sent++;
                if (sent == len) start = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        start = 1'b0;
        chk("load_accepted", sent, len);
    endtask

    task automatic run_block(input int len, input int mode, input int hold_at, input int hold_len,
                             input bit preset);
        int w0 = wq.size();
        int r0 = rq.size();
        int v0 = vq.size();
        int a0 = acc_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int b0 = bv_bad;
        int last_acc = 0;
        int last_vcyc = -1;
        int t = 0;
        int extra;
        if (!preset) begin
            for (int i = 0; i < len; i++) begin
                m[i] = DW'($urandom);
                if ($urandom_range(0, 7) == 0) m[i] = 12'sh800;
                if ($urandom_range(0, 7) == 0) m[i] = 12'sh7ff;
            end
        end
        load_block(len, mode);
`ifdef GAMMA_SEQ_HOLD_EN
        if (hold_at >= 0) begin
            repeat (hold_at) @(posedge clock);
            #1 hold = 1'b1;
            repeat (hold_len) @(posedge clock);
            #1 hold = 1'b0;
        end
`endif
        while (done_cnt == d0 && t < 3 * DEPTH) begin
            @(negedge clock);
            t++;
        end
        @(negedge clock);
        chk("done_count", done_cnt - d0, 1);
        chk("busy_after", int'(busy), 0);
        chk("ready_after", int'(in_ready), 0);
        chk("valid_after", int'(fwd_valid), 0);
        chk("err_none", err_cnt - e0, 0);
        chk("bwd_valid_align", bv_bad - b0, 0);
        chk("n_writes", wq.size() - w0, len);
        chk("n_reads", rq.size() - r0, len);
        chk("n_valids", vq.size() - v0, len);
        if (acc_q.size() > a0) last_acc = acc_q[acc_q.size() - 1];
        for (int i = 0; i < len && (w0 + i) < wq.size() && (a0 + i) < acc_q.size(); i++) begin
            chk("wr_addr", wq[w0 + i].addr, i);
            chk("wr_data", wq[w0 + i].data, int'(m[i]));
            chk("wr_cycle", wq[w0 + i].cyc, acc_q[a0 + i] + 1);
        end
        for (int k = 0; k < len && (r0 + k) < rq.size(); k++) begin
            chk("rd_index2", rq[r0 + k].i2, k + 1);
            chk("rd_index3", rq[r0 + k].i3, len - k);
            if (k == 0 && hold_at < 0) chk("first_read_lat", rq[r0].cyc - last_acc, 2);
        end
        for (int k = 0; k < len && (v0 + k) < vq.size(); k++) begin
            extra = (hold_at >= 0 && k >= hold_at) ? hold_len : 0;
            chk("step_idx", vq[v0 + k].step, k);
            chk("fwd_data", vq[v0 + k].f, int'(m[k]));
            chk("bwd_data", vq[v0 + k].b, int'(m[len - 1 - k]));
            chk("valid_cycle", vq[v0 + k].cyc, last_acc + 3 + k + extra);
            last_vcyc = vq[v0 + k].cyc;
        end
        chk("done_cycle", done_cyc, last_vcyc);
    endtask

    task automatic run_illegal(input int len, input bit exp_err);
        int w0 = wq.size();
        int r0 = rq.size();
        @(posedge clock); #1;
        start = 1'b1;
        blk_len = LENW'(len);
        @(posedge clock); #1;
        start = 1'b0;
        chk("err_pulse", int'(err), int'(exp_err));
        chk("err_busy", int'(busy), 0);
        chk("err_ready", int'(in_ready), 0);
        @(posedge clock); #1;
        chk("err_single", int'(err), 0);
        chk("err_busy2", int'(busy), 0);
        chk("err_no_strobe", (wq.size() - w0) + (rq.size() - r0), 0);
    endtask

    typedef struct { int len; int mode; bit exp_err; } vec_t;
    vec_t vecs [0:8];

    initial begin
        vecs = '{'{0, 0, 1'b1}, '{129, 0, 1'b1}, '{1, 0, 1'b0}, '{128, 1, 1'b0}, '{255, 0, 1'b1},
                 '{2, 2, 1'b0}, '{128, 0, 1'b0}, '{33, 2, 1'b0}, '{127, 1, 1'b0}};
        reset = 1'b1;
        start = 1'b0;
        blk_len = '0;
        in_valid = 1'b0;
        in_data = '0;
`ifdef GAMMA_SEQ_HOLD_EN
        hold = 1'b0;
`endif
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;

        // Directed block with known metrics
        m[0] = 12'sd5;
        m[1] = -12'sd3;
        m[2] = 12'sd100;
        m[3] = 12'sh800;
        run_block(4, 0, -1, 0, 1'b1);

        foreach (vecs[i]) begin
            if (vecs[i].exp_err) run_illegal(vecs[i].len, vecs[i].exp_err);
            else run_block(vecs[i].len, vecs[i].mode, -1, 0, 1'b0);
        end

        // Reset during READ step 2 aborts the block; the next block must run cleanly
        for (int i = 0; i < 5; i++) m[i] = DW'($urandom);
        load_block(5, 0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
        check_reset_vals("abort");
        reset = 1'b0;
        run_block(3, 0, -1, 0, 1'b0);

`ifdef GAMMA_SEQ_HOLD_EN
        run_block(6, 0, 2, 3, 1'b0);
`endif

        for (int r = 0; r < 6; r++) begin
            run_block(int'($urandom_range(1, DEPTH)), 2, -1, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
